// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every handshake/bus signal around alu_arbiter.
//   req0_* / req1_*      : two requesters (valid/ready, op 1=mul 0=add, a, b)
//   alu_op, alu_a, alu_b : registered opcode/operands toward the combinational ALU
//   alu_c, alu_d         : ALU result low / high half
//   rsp_*                : tagged response channel (valid/ready, id, lo, hi)
//   busy                 : arbiter is executing or holding a response
// Modports: slave  = the arbiter itself
//           master = its environment (requesters, ALU, response consumer)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 512
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_c;
    logic [WIDTH-1:0] alu_d;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_lo;
    logic [WIDTH-1:0] rsp_hi;
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_c, alu_d,
        output rsp_valid, rsp_id, rsp_lo, rsp_hi,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_c, alu_d,
        input  rsp_valid, rsp_id, rsp_lo, rsp_hi,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational signed add/multiply ALU between two requesters.
// One operation at a time: grant in IDLE, hold registered operands for an
// opcode-dependent settle latency in EXEC, capture both result halves and
// present them on a tagged response channel in RESP.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_arbiter_if.slave (requesters, ALU operands/results, response, busy)
//
// Parameters: WIDTH (operand width), ADD_LAT / MUL_LAT (settle cycles, >= 1).
//
// Build option: define ALU_ARB_RR_EN for round-robin arbitration (pointer
// moves to the requester other than the one just served). Without it,
// requester 0 always wins a simultaneous request.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH   = 512,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] ADD_CNT = CNT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             alu_op_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic             rsp_valid_reg;
    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_lo_reg;
    logic [WIDTH-1:0] rsp_hi_reg;

    // Priority pointer: the requester preferred when both are valid.
`ifdef ALU_ARB_RR_EN
    logic ptr_reg;
    logic ptr;
    assign ptr = ptr_reg;
`else
    logic ptr;
    assign ptr = 1'b0;
`endif

    logic [1:0]       req_valid;
    logic             grant_any;
    logic             grant_id;
    logic [1:0]       ready_vec;
    logic             handshake;
    logic             sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    // Preferred requester if it is valid, otherwise the other one.
    always_comb begin
        grant_any = |req_valid;
        grant_id  = ptr;
        if (!req_valid[ptr]) begin
            grant_id = ~ptr;
        end
    end

    // Ready is one-hot or zero and is forced low while rst is asserted,
    // since the reset is asynchronous and the state may be about to clear.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == IDLE) && !rst && grant_any &&
                                   (grant_id == 1'(gi));
        end
    endgenerate

    assign handshake = |ready_vec;

    always_comb begin
        sel_op = bus.req0_op;
        sel_a  = bus.req0_a;
        sel_b  = bus.req0_b;
        if (grant_id) begin
            sel_op = bus.req1_op;
            sel_a  = bus.req1_a;
            sel_b  = bus.req1_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            alu_op_reg    <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_lo_reg    <= '0;
            rsp_hi_reg    <= '0;
`ifdef ALU_ARB_RR_EN
            ptr_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        alu_op_reg <= sel_op;
                        alu_a_reg  <= sel_a;
                        alu_b_reg  <= sel_b;
                        rsp_id_reg <= grant_id;
                        cnt_reg    <= sel_op ? MUL_CNT : ADD_CNT;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have been stable for the full settle time
                    // when the counter reaches zero.
                    if (cnt_reg == '0) begin
                        rsp_lo_reg    <= bus.alu_c;
                        rsp_hi_reg    <= bus.alu_d;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
`ifdef ALU_ARB_RR_EN
                        ptr_reg       <= ~rsp_id_reg;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];
    assign bus.alu_op     = alu_op_reg;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_lo     = rsp_lo_reg;
    assign bus.rsp_hi     = rsp_hi_reg;
    assign bus.busy       = (state_reg == EXEC) || (state_reg == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Bench for alu_arbiter: a default-latency 512-bit instance plus a 16-bit
// instance with ADD_LAT=3 / MUL_LAT=1. A signed add/multiply ALU stand-in
// is attached to each. Expected results come from the arithmetic rules and
// from a last-served-requester arbitration model.
// Honours ALU_ARB_RR_EN for the expected grant order.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    localparam int W        = 512;
    localparam int W2       = 16;
    localparam int ADD_LAT0 = 1;
    localparam int MUL_LAT0 = 4;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    bit   model_ptr;

    alu_arbiter_if #(.WIDTH(W))  bus0 ();
    alu_arbiter_if #(.WIDTH(W2)) bus1 ();

    alu_arbiter #(.WIDTH(W), .ADD_LAT(ADD_LAT0), .MUL_LAT(MUL_LAT0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    alu_arbiter #(.WIDTH(W2), .ADD_LAT(3), .MUL_LAT(1)) dut_lat (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Full-width signed result of op(a,b)
    function automatic logic [2*W-1:0] ref_full(input logic op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic signed [2*W-1:0] ea;
        logic signed [2*W-1:0] eb;
        ea = $signed({{W{a[W-1]}}, a});
        eb = $signed({{W{b[W-1]}}, b});
        return op ? (ea * eb) : (ea + eb);
    endfunction

    function automatic logic [2*W2-1:0] ref_full16(input logic op, input logic [W2-1:0] a,
                                                   input logic [W2-1:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return op ? 32'(sa * sb) : 32'(sa + sb);
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Combinational ALU stand-ins
    logic [2*W-1:0]  alu0_full;
    logic [2*W2-1:0] alu1_full;
    always_comb alu0_full = ref_full(bus0.alu_op, bus0.alu_a, bus0.alu_b);
    always_comb alu1_full = ref_full16(bus1.alu_op, bus1.alu_a, bus1.alu_b);
    assign bus0.alu_c = alu0_full[W-1:0];
    assign bus0.alu_d = alu0_full[2*W-1:W];
    assign bus1.alu_c = alu1_full[W2-1:0];
    assign bus1.alu_d = alu1_full[2*W2-1:W2];

    // Stimulus driver for one isolated transaction on bus0; returns what it
    // observed, the calling test does the comparisons.
    task automatic run_op(input bit id, input bit op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int rsp_delay, input bit hold_other,
                          output int wait_cyc, output int lat, output bit rid,
                          output logic [W-1:0] lo, output logic [W-1:0] hi,
                          output bit stable, output bit held);
        wait_cyc = 0; lat = 0; rid = 1'b0; lo = '0; hi = '0; stable = 1'b1; held = 1'b1;
        bus0.rsp_ready = (rsp_delay == 0);
        if (!id) begin
            bus0.req0_valid = 1'b1; bus0.req0_op = op; bus0.req0_a = a; bus0.req0_b = b;
        end else begin
            bus0.req1_valid = 1'b1; bus0.req1_op = op; bus0.req1_a = a; bus0.req1_b = b;
        end
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (!(id ? bus0.req1_ready : bus0.req0_ready) && wait_cyc < 20);
        if (!(id ? bus0.req1_ready : bus0.req0_ready)) begin
            wait_cyc = -1;
            bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0; bus0.rsp_ready = 1'b1;
            return;
        end
        @(posedge clk); #1;
        bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus0.alu_op !== op || bus0.alu_a !== a || bus0.alu_b !== b) stable = 1'b0;
        end while (!bus0.rsp_valid && lat < 30);
        if (!bus0.rsp_valid) begin
            lat = -1;
            bus0.rsp_ready = 1'b1;
            return;
        end
        rid = bus0.rsp_id; lo = bus0.rsp_lo; hi = bus0.rsp_hi;
        if (hold_other) begin
            if (!id) begin bus0.req1_valid = 1'b1; bus0.req1_op = 1'b0; end
            else     begin bus0.req0_valid = 1'b1; bus0.req0_op = 1'b0; end
        end
        for (int i = 0; i < rsp_delay; i++) begin
            @(posedge clk); #1;
            if (i == rsp_delay - 1) bus0.rsp_ready = 1'b1;
            @(negedge clk);
            if (!(bus0.rsp_valid === 1'b1 && bus0.rsp_id === rid && bus0.rsp_lo === lo &&
                  bus0.rsp_hi === hi && bus0.req0_ready === 1'b0 &&
                  bus0.req1_ready === 1'b0 && bus0.busy === 1'b1)) held = 1'b0;
        end
        @(posedge clk); #1;
        bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
        bus0.rsp_ready = 1'b1;
        model_ptr = RR ? ~id : 1'b0;
        $display("txn id=%0d op=%0d wait=%0d lat=%0d rsp_id=%0d", id, op, wait_cyc, lat, rid);
    endtask

    task automatic test_reset();
        bus0.req0_valid = 1'b1; bus0.req1_valid = 1'b1;
        bus1.req0_valid = 1'b1; bus1.req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus0.req0_ready !== 1'b0 || bus0.req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b%b want 00", bus0.req1_ready, bus0.req0_ready); end
        checks++; if (bus1.req0_ready !== 1'b0 || bus1.req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_lat got %b%b want 00", bus1.req1_ready, bus1.req0_ready); end
        checks++; if (bus0.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid got %b want 0", bus0.rsp_valid); end
        checks++; if (bus0.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
        checks++; if (bus0.alu_op !== 1'b0 || bus0.alu_a !== '0 || bus0.alu_b !== '0) begin
            errors++; $display("FAIL reset_alu got op=%b a=%h b=%h want zeros", bus0.alu_op, bus0.alu_a, bus0.alu_b); end
        checks++; if (bus0.rsp_id !== 1'b0 || bus0.rsp_lo !== '0 || bus0.rsp_hi !== '0) begin
            errors++; $display("FAIL reset_rsp got id=%b lo=%h hi=%h want zeros", bus0.rsp_id, bus0.rsp_lo, bus0.rsp_hi); end
        bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
        bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_add_req0();
        logic [W-1:0] a, b, lo, hi, exp_lo, exp_hi;
        int wc, lat; bit rid, st, hd;
        a = '0; a[3:0] = 4'd5;
        b = '1; b[3:0] = 4'b1001;          // -7
        exp_lo = '1; exp_lo[0] = 1'b0;     // -2
        exp_hi = '1;
        run_op(1'b0, 1'b0, a, b, 0, 1'b0, wc, lat, rid, lo, hi, st, hd);
        checks++; if (wc !== 1) begin errors++; $display("FAIL add_first_ready got wait=%0d want 1", wc); end
        checks++; if (lat !== 1 + ADD_LAT0) begin errors++; $display("FAIL add_latency got %0d want %0d", lat, 1 + ADD_LAT0); end
        checks++; if (rid !== 1'b0) begin errors++; $display("FAIL add_rsp_id got %0d want 0", rid); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL add_lo got %h want %h", lo, exp_lo); end
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL add_hi got %h want %h", hi, exp_hi); end
        checks++; if (bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_done got rsp_valid=%b want 0", bus0.rsp_valid); end
    endtask

    task automatic test_mul_req1();
        logic [W-1:0] a, lo, hi, exp_hi;
        int wc, lat; bit rid, st, hd;
        a = '0; a[300] = 1'b1;
        exp_hi = '0; exp_hi[600 - W] = 1'b1;  // 2^600
        run_op(1'b1, 1'b1, a, a, 0, 1'b0, wc, lat, rid, lo, hi, st, hd);
        checks++; if (lat !== 1 + MUL_LAT0) begin errors++; $display("FAIL mul_latency got %0d want %0d", lat, 1 + MUL_LAT0); end
        checks++; if (rid !== 1'b1) begin errors++; $display("FAIL mul_rsp_id got %0d want 1", rid); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL mul_alu_stable got %b want 1", st); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL mul_lo got %h want 0", lo); end
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL mul_hi got %h want %h", hi, exp_hi); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, lo, hi;
        logic [2*W-1:0] full;
        int wc, lat; bit op, rid, st, hd;
        a = rand_w(); b = rand_w(); op = 1'($urandom_range(0, 1));
        full = ref_full(op, a, b);
        run_op(1'b0, op, a, b, 10, 1'b1, wc, lat, rid, lo, hi, st, hd);
        checks++; if (hd !== 1'b1) begin errors++; $display("FAIL bp_hold got %b want 1", hd); end
        checks++; if (lo !== full[W-1:0]) begin errors++; $display("FAIL bp_lo got %h want %h", lo, full[W-1:0]); end
        checks++; if (hi !== full[2*W-1:W]) begin errors++; $display("FAIL bp_hi got %h want %h", hi, full[2*W-1:W]); end
        checks++; if (bus0.rsp_valid !== 1'b0 || bus0.busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", bus0.rsp_valid, bus0.busy); end
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] a, b, lo, hi;
        logic [2*W-1:0] full;
        int wc, lat; bit rid, st, hd, seen;
        bus0.req0_valid = 1'b1; bus0.req0_op = 1'b1;
        bus0.req0_a = rand_w(); bus0.req0_b = rand_w();
        wc = 0;
        do begin @(negedge clk); wc++; end while (!bus0.req0_ready && wc < 20);
        checks++; if (bus0.req0_ready !== 1'b1) begin errors++; $display("FAIL rstmid_accept got %b want 1", bus0.req0_ready); end
        @(posedge clk); #1;
        bus0.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; bus0.req1_valid = 1'b1;
        #1;
        checks++; if (bus0.busy !== 1'b0 || bus0.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_state got busy=%b valid=%b want 0 0", bus0.busy, bus0.rsp_valid); end
        checks++; if (bus0.alu_op !== 1'b0 || bus0.alu_a !== '0 || bus0.alu_b !== '0) begin
            errors++; $display("FAIL rstmid_alu got op=%b a=%h want zeros", bus0.alu_op, bus0.alu_a); end
        checks++; if (bus0.req1_ready !== 1'b0 || bus0.rsp_id !== 1'b0 || bus0.rsp_lo !== '0) begin
            errors++; $display("FAIL rstmid_outs got rdy1=%b id=%b want 0 0", bus0.req1_ready, bus0.rsp_id); end
        @(posedge clk); #1;
        rst = 1'b0; bus0.req1_valid = 1'b0;
        model_ptr = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (bus0.rsp_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp got rsp_valid seen=%b want 0", seen); end
        @(posedge clk); #1;
        a = rand_w(); b = rand_w();
        full = ref_full(1'b0, a, b);
        run_op(1'b1, 1'b0, a, b, 0, 1'b0, wc, lat, rid, lo, hi, st, hd);
        checks++; if (lat !== 1 + ADD_LAT0 || rid !== 1'b1) begin
            errors++; $display("FAIL rstmid_next got lat=%0d id=%0d want %0d 1", lat, rid, 1 + ADD_LAT0); end
        checks++; if (lo !== full[W-1:0] || hi !== full[2*W-1:W]) begin
            errors++; $display("FAIL rstmid_result got lo=%h want %h", lo, full[W-1:0]); end
    endtask

    // Both requesters valid every cycle, rsp_ready tied high
    task automatic test_back_to_back();
        logic [W-1:0] a0 [4];
        logic [W-1:0] b0 [4];
        logic [W-1:0] a1 [4];
        logic [W-1:0] b1 [4];
        bit o0 [4];
        bit o1 [4];
        bit seq [4];
        bit want_seq [4];
        bit exp_id_q [$];
        logic [2*W-1:0] exp_full_q [$];
        int idx0, idx1, n_rsp, n_hs, last_hs, last_lat, cycles;
        for (int i = 0; i < 4; i++) begin
            a0[i] = rand_w(); b0[i] = rand_w(); o0[i] = 1'($urandom_range(0, 1));
            a1[i] = rand_w(); b1[i] = rand_w(); o1[i] = 1'($urandom_range(0, 1));
            seq[i] = 1'b0;
            want_seq[i] = RR ? 1'(i % 2) : 1'b0;
        end
        idx0 = 0; idx1 = 0; n_rsp = 0; n_hs = 0; last_hs = 0; last_lat = 0; cycles = 0;
        bus0.rsp_ready = 1'b1;
        while (n_rsp < 4 && cycles < 200) begin
            bus0.req0_valid = (idx0 < 4);
            if (idx0 < 4) begin bus0.req0_op = o0[idx0]; bus0.req0_a = a0[idx0]; bus0.req0_b = b0[idx0]; end
            bus0.req1_valid = (idx1 < 4);
            if (idx1 < 4) begin bus0.req1_op = o1[idx1]; bus0.req1_a = a1[idx1]; bus0.req1_b = b1[idx1]; end
            @(negedge clk);
            cycles++;
            if (bus0.req0_ready || bus0.req1_ready) begin
                bit got, want, gop;
                got = bus0.req1_ready;
                if (bus0.req0_valid && bus0.req1_valid) want = RR ? model_ptr : 1'b0;
                else want = bus0.req1_valid;
                checks++;
                if ((bus0.req0_ready && bus0.req1_ready) || got !== want) begin
                    errors++; $display("FAIL b2b_grant got rdy=%b%b want id %0d", bus0.req1_ready, bus0.req0_ready, want);
                end
                gop = got ? o1[idx1] : o0[idx0];
                exp_id_q.push_back(got);
                exp_full_q.push_back(got ? ref_full(o1[idx1], a1[idx1], b1[idx1])
                                         : ref_full(o0[idx0], a0[idx0], b0[idx0]));
                if (n_hs > 0) begin
                    checks++;
                    if (cyc - last_hs !== last_lat + 2) begin
                        errors++; $display("FAIL b2b_spacing got %0d want %0d", cyc - last_hs, last_lat + 2);
                    end
                end
                last_hs = cyc; last_lat = gop ? MUL_LAT0 : ADD_LAT0; n_hs++;
                if (got) idx1++; else idx0++;
            end
            if (bus0.rsp_valid && exp_id_q.size() > 0) begin
                bit eid;
                logic [2*W-1:0] ef;
                eid = exp_id_q.pop_front();
                ef = exp_full_q.pop_front();
                checks++; if (bus0.rsp_id !== eid) begin errors++; $display("FAIL b2b_rsp_id got %0d want %0d", bus0.rsp_id, eid); end
                checks++; if (bus0.rsp_lo !== ef[W-1:0] || bus0.rsp_hi !== ef[2*W-1:W]) begin
                    errors++; $display("FAIL b2b_result got lo=%h want %h", bus0.rsp_lo, ef[W-1:0]); end
                $display("txn b2b rsp_id=%0d n=%0d", bus0.rsp_id, n_rsp);
                seq[n_rsp] = bus0.rsp_id;
                model_ptr = RR ? ~eid : 1'b0;
                n_rsp++;
            end
            @(posedge clk); #1;
        end
        bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
        checks++; if (n_rsp !== 4) begin errors++; $display("FAIL b2b_timeout got %0d responses want 4", n_rsp); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq[i] !== want_seq[i]) begin
                errors++; $display("FAIL b2b_seq[%0d] got %0d want %0d", i, seq[i], want_seq[i]);
            end
        end
    endtask

    task automatic test_latency_params();
        for (int k = 0; k < 2; k++) begin
            bit op;
            logic [W2-1:0] a, b;
            logic [2*W2-1:0] full;
            int wc, lat, want;
            op = (k == 1);
            a = 16'($urandom); b = 16'($urandom);
            want = op ? 2 : 4;
            full = ref_full16(op, a, b);
            bus1.req0_valid = 1'b1; bus1.req0_op = op; bus1.req0_a = a; bus1.req0_b = b;
            bus1.rsp_ready = 1'b1;
            wc = 0;
            do begin @(negedge clk); wc++; end while (!bus1.req0_ready && wc < 20);
            checks++;
            if (bus1.req0_ready !== 1'b1) begin
                errors++; $display("FAIL lat_accept got ready=%b want 1", bus1.req0_ready);
                bus1.req0_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
                bus1.req0_valid = 1'b0;
                lat = 0;
                do begin @(negedge clk); lat++; end while (!bus1.rsp_valid && lat < 30);
                checks++; if (lat !== want) begin errors++; $display("FAIL lat_op%0d got %0d want %0d", op, lat, want); end
                checks++; if (bus1.rsp_lo !== full[W2-1:0] || bus1.rsp_hi !== full[2*W2-1:W2]) begin
                    errors++; $display("FAIL lat_result got %h%h want %h", bus1.rsp_hi, bus1.rsp_lo, full); end
                $display("txn lat op=%0d lat=%0d", op, lat);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; model_ptr = 1'b0;
        rst = 1'b1;
        bus0.req0_valid = 1'b0; bus0.req0_op = 1'b0; bus0.req0_a = '0; bus0.req0_b = '0;
        bus0.req1_valid = 1'b0; bus0.req1_op = 1'b0; bus0.req1_a = '0; bus0.req1_b = '0;
        bus0.rsp_ready = 1'b1;
        bus1.req0_valid = 1'b0; bus1.req0_op = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0;
        bus1.req1_valid = 1'b0; bus1.req1_op = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0;
        bus1.rsp_ready = 1'b1;
        test_reset();
        test_add_req0();
        test_mul_req1();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        test_latency_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
